// File: rtl/deshift_pkg.sv
// Serial-link constants shared by the shifter and deshifter ends of the link.
// Words travel MSB first. Each new bit enters at the LSB end and older bits
// move toward the MSB.
package deshift_pkg;

  localparam int MAX_WIDTH = 32;

  // Pushes one received bit into a word using the link's MSB-first order.
  function automatic logic [MAX_WIDTH-1:0] shift_msb_first(
    input logic [MAX_WIDTH-1:0] word,
    input logic                 bit_in
  );
    return (word << 1) | MAX_WIDTH'(bit_in);
  endfunction

endpackage

// File: rtl/deshift.sv
// Serial-in, parallel-out deserializer. It collects WIDTH bits, MSB first,
// into a word. Each completed word is held in a registered output with a
// valid/ack handshake. A sticky overrun flag records when a word was
// replaced before the consumer took it.
module deshift
  import deshift_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ack,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_cnt
);

  // Index of the last bit in a word. The counter wraps explicitly at this
  // value, so power-of-two widths do not depend on natural rollover.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] next_word;
  logic             word_done;

  assign next_word = WIDTH'(shift_msb_first(MAX_WIDTH'(sr), in));
  assign word_done = en && !clr && (bit_cnt == LAST);

  // Shift register and bit counter. A frame restart beats a bit strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (en) begin
      sr <= next_word;
      if (bit_cnt == LAST) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

  // Output word, valid/ack handshake and sticky overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (word_done) begin
        out       <= next_word;
        out_valid <= 1'b1;
      end else if (out_valid && out_ack) begin
        out_valid <= 1'b0;
      end

      if (clr) begin
        overrun <= 1'b0;
      end else if (word_done && out_valid && !out_ack) begin
        overrun <= 1'b1;
      end
    end
  end

  // The counter never goes past the last bit index.
  a_cnt_range : assert property (@(posedge clk) disable iff (!rst)
    bit_cnt <= LAST);

  // A held word does not change unless a new word completes on top of it.
  a_out_stable : assert property (@(posedge clk) disable iff (!rst)
    (out_valid && !word_done) |=> (out == $past(out)));

endmodule

// File: tb/tb_deshift.sv
// Self-checking bench for deshift at WIDTH=4.
// It runs a directed vector table, then hand-written reset sequences, then
// random traffic compared against a queue-based reference model.
module tb_deshift;

  localparam int WIDTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ser_in = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       out_ack = 1'b0;
  logic [3:0] out;
  logic       out_valid;
  logic       overrun;
  logic [1:0] bit_cnt;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic       en;
    logic       din;
    logic       clr;
    logic       ack;
    logic [3:0] exp_out;
    logic       exp_valid;
    logic       exp_ovr;
    logic [1:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: received bits of the partial word and the
  // consumer-visible word, valid and overrun.
  bit         m_bits[$];
  logic [3:0] m_out;
  logic       m_valid;
  logic       m_ovr;

  deshift #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (ser_in),
    .en        (en),
    .clr       (clr),
    .out       (out),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .overrun   (overrun),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic compare(input string tag, input string field,
                         input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s.%s actual=%0h required=%0h", tag, field, act, req);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] e_out,
                             input logic e_valid, input logic e_ovr,
                             input logic [1:0] e_cnt);
    compare(tag, "out", 32'(out), 32'(e_out));
    compare(tag, "out_valid", 32'(out_valid), 32'(e_valid));
    compare(tag, "overrun", 32'(overrun), 32'(e_ovr));
    compare(tag, "bit_cnt", 32'(bit_cnt), 32'(e_cnt));
  endtask

  // Drives inputs at the falling edge. It then waits one rising edge and
  // settles so the outputs can be sampled away from the edge.
  task automatic applyStimulus(input logic v_en, input logic v_in,
                               input logic v_clr, input logic v_ack);
    @(negedge clk);
    en      = v_en;
    ser_in  = v_in;
    clr     = v_clr;
    out_ack = v_ack;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic v_en, input logic v_in,
                              input logic v_clr, input logic v_ack,
                              input logic [3:0] e_out, input logic e_valid,
                              input logic e_ovr, input logic [1:0] e_cnt);
    vec_t v;
    v.en = v_en; v.din = v_in; v.clr = v_clr; v.ack = v_ack;
    v.exp_out = e_out; v.exp_valid = e_valid; v.exp_ovr = e_ovr; v.exp_cnt = e_cnt;
    vecs.push_back(v);
  endfunction

  // Applies the consumer-visible rules to one clock edge of the model.
  function automatic void model_step(input logic v_en, input logic v_in,
                                     input logic v_clr, input logic v_ack);
    bit         completed = 0;
    logic [3:0] word = '0;
    if (v_clr) begin
      m_bits.delete();
      m_ovr = 1'b0;
    end else if (v_en) begin
      m_bits.push_back(v_in);
      if (m_bits.size() == WIDTH) begin
        foreach (m_bits[i]) word = 4'((word * 2) + m_bits[i]);
        m_bits.delete();
        completed = 1;
      end
    end
    if (completed) begin
      if (m_valid && !v_ack) m_ovr = 1'b1;
      m_out   = word;
      m_valid = 1'b1;
    end else if (m_valid && v_ack) begin
      m_valid = 1'b0;
    end
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic v_en, v_in, v_clr, v_ack;

    // Directed vectors: en, in, clr, ack -> out, valid, overrun, bit_cnt
    add(1,1,0,0, 4'b0000,0,0,2'd1);
    add(1,0,0,0, 4'b0000,0,0,2'd2);
    add(1,1,0,0, 4'b0000,0,0,2'd3);
    add(1,1,0,0, 4'b1011,1,0,2'd0);
    add(0,0,0,1, 4'b1011,0,0,2'd0);
    add(1,0,0,0, 4'b1011,0,0,2'd1);
    add(0,1,0,0, 4'b1011,0,0,2'd1);
    add(1,1,0,0, 4'b1011,0,0,2'd2);
    add(0,0,0,0, 4'b1011,0,0,2'd2);
    add(1,1,0,0, 4'b1011,0,0,2'd3);
    add(0,1,0,0, 4'b1011,0,0,2'd3);
    add(1,0,0,0, 4'b0110,1,0,2'd0);
    add(0,0,0,1, 4'b0110,0,0,2'd0);
    add(1,1,0,0, 4'b0110,0,0,2'd1);
    add(1,1,0,0, 4'b0110,0,0,2'd2);
    add(1,0,0,0, 4'b0110,0,0,2'd3);
    add(1,0,0,0, 4'b1100,1,0,2'd0);
    add(1,0,0,0, 4'b1100,1,0,2'd1);
    add(1,0,0,0, 4'b1100,1,0,2'd2);
    add(1,1,0,0, 4'b1100,1,0,2'd3);
    add(1,1,0,0, 4'b0011,1,1,2'd0);
    add(0,0,0,1, 4'b0011,0,1,2'd0);
    add(0,0,1,0, 4'b0011,0,0,2'd0);
    add(1,1,0,0, 4'b0011,0,0,2'd1);
    add(1,0,0,0, 4'b0011,0,0,2'd2);
    add(1,1,0,0, 4'b0011,0,0,2'd3);
    add(1,0,0,0, 4'b1010,1,0,2'd0);
    add(1,0,0,0, 4'b1010,1,0,2'd1);
    add(1,1,0,0, 4'b1010,1,0,2'd2);
    add(1,0,0,0, 4'b1010,1,0,2'd3);
    add(1,1,0,1, 4'b0101,1,0,2'd0);
    add(1,1,0,0, 4'b0101,1,0,2'd1);
    add(1,1,0,0, 4'b0101,1,0,2'd2);
    add(1,1,1,0, 4'b0101,1,0,2'd0);
    add(1,1,0,1, 4'b0101,0,0,2'd1);
    add(1,0,0,0, 4'b0101,0,0,2'd2);
    add(1,0,0,0, 4'b0101,0,0,2'd3);
    add(1,1,0,0, 4'b1001,1,0,2'd0);

    // Power-on reset
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", 4'b0000, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].en, vecs[i].din, vecs[i].clr, vecs[i].ack);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_valid,
                  vecs[i].exp_ovr, vecs[i].exp_cnt);
    end

    // Asynchronous reset mid-word with a held word pending
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("pre_async", 4'b1001, 1'b1, 1'b0, 2'd3);
    @(negedge clk);
    en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst", 4'b0000, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("post_rst_cnt", 4'b0000, 1'b0, 1'b0, 2'd3);
    applyStimulus(1, 0, 0, 0);
    checkOutput("post_rst_word", 4'b1110, 1'b1, 1'b0, 2'd0);

    // Random traffic compared against the reference model
    @(negedge clk);
    en = 1'b0; clr = 1'b0; out_ack = 1'b0;
    rst = 1'b0;
    m_bits.delete();
    m_out = '0; m_valid = 1'b0; m_ovr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 600; n++) begin
      v_en  = ($urandom_range(0, 9) < 7);
      v_in  = 1'($urandom_range(0, 1));
      v_clr = ($urandom_range(0, 19) == 0);
      v_ack = ($urandom_range(0, 9) < 3);
      applyStimulus(v_en, v_in, v_clr, v_ack);
      model_step(v_en, v_in, v_clr, v_ack);
      checkOutput($sformatf("rand%0d", n), m_out, m_valid, m_ovr,
                  2'(m_bits.size()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
